gb_fb_bank_writer: RTL and testbench

Write-side controller for a multi-bank GameBoy LCD framebuffer. It takes the PPU pixel stream (LD/PX_VALID) and generates linear write addresses from parametrised X/Y counters. Completed frames rotate through 2 (double) or 3 (triple) RAM banks so the VGA scaler always reads a whole, tear-free frame. Bank release is handshaked from the VGA domain with a toggle that is synchronised into GameBoy_clk.

---
 rtl/gb_fb_bank_writer.sv | 179 +++++++++++++++++
 tb/tb_gb_fb_bank_writer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_fb_bank_writer.sv
// Write-side controller for a 2/3-bank GameBoy LCD framebuffer.
// Optional FB_VSYNC_RESYNC_EN: lcd_vsync realigns the counters to (0,0).
module gb_fb_bank_writer #(
  parameter int H_PIXELS  = 160,
  parameter int V_PIXELS  = 144,
  parameter int PIXEL_W   = 2,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = $clog2(H_PIXELS * V_PIXELS)
) (
  input  logic               GameBoy_clk,
  input  logic               GameBoy_reset,
  input  logic [PIXEL_W-1:0] px_data,
  input  logic               px_valid,
  input  logic               lcd_vsync,
  input  logic               rd_ack_tgl,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIXEL_W-1:0] wr_data,
  output logic [1:0]         wr_bank,
  output logic [1:0]         rd_bank,
  output logic               pending_valid,
  output logic               frame_done,
  output logic [7:0]         frames_dropped,
  output logic               resync_err
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

  generate
    if (NUM_BANKS != 2 && NUM_BANKS != 3) begin : g_bad_banks
      $error("NUM_BANKS must be 2 or 3");
    end
  endgenerate

  typedef enum logic [1:0] {FILL, HOLD, SKIP} state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] base;
  logic [1:0]        pb;
  logic              s1, s2, s3;
  logic              ack, vs, acc, last, at_origin, drop;

`ifdef FB_VSYNC_RESYNC_EN
  assign vs = lcd_vsync;
`else
  logic unused_vsync;
  assign unused_vsync = lcd_vsync;
  assign vs = 1'b0;
`endif

  assign ack       = s2 ^ s3;
  assign acc       = px_valid && !vs;
  assign last      = acc && (x == X_LAST) && (y == Y_LAST);
  assign at_origin = (x == '0) && (y == '0);

  always_comb begin
    drop = 1'b0;
    if (NUM_BANKS == 3) drop = last && pending_valid;
    else drop = (state == HOLD) && last && !ack;
  end

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rd_ack_tgl;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // base tracks y*H_PIXELS so the address needs only an adder
  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      x    <= '0;
      y    <= '0;
      base <= '0;
    end else if (vs) begin
      x    <= '0;
      y    <= '0;
      base <= '0;
    end else if (px_valid) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y    <= '0;
          base <= '0;
        end else begin
          y    <= y + 1'b1;
          base <= base + ADDR_W'(H_PIXELS);
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      wr_en      <= acc && (state == FILL);
      frame_done <= last;
      resync_err <= vs && !at_origin;
      if (acc) begin
        wr_addr <= base + ADDR_W'(x);
        wr_data <= px_data;
      end
    end
  end

  // in triple mode pb holds the free bank whenever nothing is pending
  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      state          <= FILL;
      wr_bank        <= 2'd0;
      rd_bank        <= 2'(NUM_BANKS - 1);
      pb             <= 2'd1;
      pending_valid  <= 1'b0;
      frames_dropped <= 8'd0;
    end else begin
      if (drop && frames_dropped != 8'hFF)
        frames_dropped <= frames_dropped + 8'd1;
      if (NUM_BANKS == 3) begin
        if (last && ack) begin
          rd_bank       <= wr_bank;
          wr_bank       <= pending_valid ? pb : rd_bank;
          pb            <= pending_valid ? rd_bank : pb;
          pending_valid <= 1'b0;
        end else if (last) begin
          pb            <= wr_bank;
          wr_bank       <= pb;
          pending_valid <= 1'b1;
        end else if (ack && pending_valid) begin
          rd_bank       <= pb;
          pb            <= rd_bank;
          pending_valid <= 1'b0;
        end
      end else begin
        pending_valid <= 1'b0;
        unique case (state)
          FILL: begin
            if (last) begin
              if (ack) begin
                wr_bank <= rd_bank;
                rd_bank <= wr_bank;
              end else begin
                state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (ack) begin
              wr_bank <= rd_bank;
              rd_bank <= wr_bank;
              state   <= (last || vs) ? FILL : SKIP;
            end
          end
          SKIP: begin
            if (last || vs) state <= FILL;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_fb_bank_writer.sv
// Randomised self-checking bench for gb_fb_bank_writer.
// Transaction-level model: frame pixel index and bank roles.
module tb_gb_fb_bank_writer;

`ifdef FB_VSYNC_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] px_data = 2'd0;
  logic       px_valid = 1'b0;
  logic       lcd_vsync = 1'b0;
  logic       rd_ack_tgl = 1'b0;

  logic        en0, en1, en2, fd0, fd1, fd2;
  logic        pv0, pv1, pv2, re0, re1, re2;
  logic [14:0] addr0;
  logic [4:0]  addr1, addr2;
  logic [1:0]  data0, data1, data2;
  logic [1:0]  wb0, wb1, wb2, rb0, rb1, rb2;
  logic [7:0]  dr0, dr1, dr2;

  always #5 clk = ~clk;

  gb_fb_bank_writer u_def (
    .GameBoy_clk(clk), .GameBoy_reset(rst),
    .px_data(px_data), .px_valid(px_valid),
    .lcd_vsync(lcd_vsync), .rd_ack_tgl(rd_ack_tgl),
    .wr_en(en0), .wr_addr(addr0), .wr_data(data0),
    .wr_bank(wb0), .rd_bank(rb0), .pending_valid(pv0),
    .frame_done(fd0), .frames_dropped(dr0),
    .resync_err(re0));

  gb_fb_bank_writer #(.H_PIXELS(8), .V_PIXELS(4), .NUM_BANKS(2)) u_dbl (
    .GameBoy_clk(clk), .GameBoy_reset(rst),
    .px_data(px_data), .px_valid(px_valid),
    .lcd_vsync(lcd_vsync), .rd_ack_tgl(rd_ack_tgl),
    .wr_en(en1), .wr_addr(addr1), .wr_data(data1),
    .wr_bank(wb1), .rd_bank(rb1), .pending_valid(pv1),
    .frame_done(fd1), .frames_dropped(dr1),
    .resync_err(re1));

  gb_fb_bank_writer #(.H_PIXELS(8), .V_PIXELS(4), .NUM_BANKS(3)) u_tri (
    .GameBoy_clk(clk), .GameBoy_reset(rst),
    .px_data(px_data), .px_valid(px_valid),
    .lcd_vsync(lcd_vsync), .rd_ack_tgl(rd_ack_tgl),
    .wr_en(en2), .wr_addr(addr2), .wr_data(data2),
    .wr_bank(wb2), .rd_bank(rb2), .pending_valid(pv2),
    .frame_done(fd2), .frames_dropped(dr2),
    .resync_err(re2));

  int checks = 0;
  int passed = 0;

  int m_pix[3], m_mode[3], m_w[3], m_p[3], m_d[3];
  int m_drop[3], m_addr[3], m_data[3];
  bit m_pend[3], m_en[3], m_fd[3], m_re[3];
  bit t1, t2, t3;

  function automatic int npix(input int i);
    return (i == 0) ? 23040 : 32;
  endfunction

  function automatic int nb(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic logic rv();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pix[i] = 0; m_mode[i] = 0;
      m_w[i] = 0; m_p[i] = 1; m_d[i] = nb(i) - 1;
      m_pend[i] = 0; m_drop[i] = 0;
      m_en[i] = 0; m_fd[i] = 0; m_re[i] = 0;
      m_addr[i] = 0; m_data[i] = 0;
    end
    t1 = 0; t2 = 0; t3 = 0;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] dat,
                            input logic vs);
    logic ack, vse, last;
    int n, tmp;
    ack = t2 ^ t3;
    t3 = t2; t2 = t1; t1 = rd_ack_tgl;
    vse = vs && RESYNC;
    for (int i = 0; i < 3; i++) begin
      n = npix(i);
      last = v && !vse && (m_pix[i] == n - 1);
      m_en[i] = v && !vse && (m_mode[i] == 0);
      m_fd[i] = last;
      m_re[i] = vse && (m_pix[i] != 0);
      if (v && !vse) begin
        m_addr[i] = m_pix[i];
        m_data[i] = int'(dat);
      end
      if (nb(i) == 3) begin
        if (last && ack) begin
          if (m_pend[i]) m_drop[i]++;
          tmp = m_w[i];
          m_w[i] = m_pend[i] ? m_p[i] : m_d[i];
          m_d[i] = tmp;
          m_pend[i] = 0;
        end else if (last) begin
          if (m_pend[i]) m_drop[i]++;
          tmp = m_pend[i] ? m_p[i] : 3 - m_w[i] - m_d[i];
          m_p[i] = m_w[i];
          m_w[i] = tmp;
          m_pend[i] = 1;
        end else if (ack && m_pend[i]) begin
          m_d[i] = m_p[i];
          m_pend[i] = 0;
        end
      end else begin
        case (m_mode[i])
          0: if (last) begin
            if (ack) begin
              tmp = m_w[i]; m_w[i] = m_d[i]; m_d[i] = tmp;
            end else m_mode[i] = 1;
          end
          1: if (ack) begin
            tmp = m_w[i]; m_w[i] = m_d[i]; m_d[i] = tmp;
            m_mode[i] = (last || vse) ? 0 : 2;
          end else if (last) m_drop[i]++;
          default: if (last || vse) m_mode[i] = 0;
        endcase
      end
      if (m_drop[i] > 255) m_drop[i] = 255;
      if (vse) m_pix[i] = 0;
      else if (v) m_pix[i] = (m_pix[i] + 1) % n;
    end
  endtask

  function automatic logic [33:0] act(input int i);
    logic e, f, p, r;
    logic [1:0] w, b, d;
    logic [7:0] c;
    logic [15:0] a;
    case (i)
      0: begin
        e = en0; f = fd0; w = wb0; b = rb0; p = pv0;
        c = dr0; r = re0; a = 16'(addr0); d = data0;
      end
      1: begin
        e = en1; f = fd1; w = wb1; b = rb1; p = pv1;
        c = dr1; r = re1; a = 16'(addr1); d = data1;
      end
      default: begin
        e = en2; f = fd2; w = wb2; b = rb2; p = pv2;
        c = dr2; r = re2; a = 16'(addr2); d = data2;
      end
    endcase
    if (e !== 1'b1) begin a = '0; d = '0; end
    return {e, f, w, b, p, c, r, a, d};
  endfunction

  function automatic logic [33:0] exp_vec(input int i);
    logic [15:0] a;
    logic [1:0] d;
    a = m_en[i] ? 16'(m_addr[i]) : 16'd0;
    d = m_en[i] ? 2'(m_data[i]) : 2'd0;
    return {m_en[i], m_fd[i], 2'(m_w[i]), 2'(m_d[i]),
            m_pend[i], 8'(m_drop[i]), m_re[i], a, d};
  endfunction

  task automatic step(input logic v, input logic [1:0] dat,
                      input logic vs);
    px_valid = v; px_data = dat; lcd_vsync = vs;
    @(posedge clk);
    model_edge(v, dat, vs);
    #1;
  endtask

  task automatic apply_reset();
    px_valid = 0; lcd_vsync = 0; rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [33:0] e;
    rst = 1;
    #2;
    for (int i = 0; i < 3; i++) begin
      e = {2'b00, 2'd0, 2'(nb(i) - 1), 1'b0, 8'd0, 1'b0, 18'd0};
      checks++;
      if (act(i) !== e)
        $display("FAIL reset dut%0d got %h want %h", i, act(i), e);
      else passed++;
    end
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_full_frame();
    int sent = 0, fdn = 0, fda = -1, g = 0;
    apply_reset();
    while (sent < 23040 && g < 40000) begin
      step(rv(), 2'($urandom), 1'b0);
      g++;
      if (px_valid) sent++;
      checks++;
      if (act(0) !== exp_vec(0))
        $display("FAIL full_frame cyc %0d got %h want %h",
                 g, act(0), exp_vec(0));
      else passed++;
      if (fd0 === 1'b1) begin fdn++; fda = int'(addr0); end
    end
    checks++;
    if (fdn !== 1 || fda !== 23039 || sent !== 23040)
      $display("FAIL full_frame_done got n=%0d a=%0d s=%0d want n=1 a=23039 s=23040",
               fdn, fda, sent);
    else passed++;
  endtask

  task automatic test_two_bank_skip();
    int sent = 0, g = 0, tc = 0, lat = -1, mid = 0, first = -1, fb = -1;
    bit tog = 0;
    apply_reset();
    while (sent < 72 && g < 600) begin
      if (sent == 52 && !tog) begin
        rd_ack_tgl = ~rd_ack_tgl; tog = 1;
      end
      step(rv(), 2'($urandom), 1'b0);
      g++;
      if (px_valid) sent++;
      if (tog) begin
        tc++;
        if (lat < 0 && rb1 !== 2'd1) lat = tc;
      end
      checks++;
      if (act(1) !== exp_vec(1))
        $display("FAIL skip cyc %0d got %h want %h",
                 g, act(1), exp_vec(1));
      else passed++;
      if (sent > 32 && sent <= 64 && en1 === 1'b1) mid++;
      if (sent > 64 && first < 0 && en1 === 1'b1) begin
        first = int'(addr1); fb = int'(wb1);
      end
    end
    checks++;
    if (lat !== 3)
      $display("FAIL skip_latency got %0d want 3", lat);
    else passed++;
    checks++;
    if (mid !== 0)
      $display("FAIL skip_suppress got %0d writes want 0", mid);
    else passed++;
    checks++;
    if (first !== 0 || fb !== 1)
      $display("FAIL skip_first got a=%0d b=%0d want a=0 b=1", first, fb);
    else passed++;
  endtask

  task automatic test_two_bank_drop();
    int sent = 0, g = 0, wn = 0;
    apply_reset();
    repeat (10) step(1'b1, 2'($urandom), 1'b0);
    apply_reset();
    while (sent < 96 && g < 800) begin
      step(rv(), 2'($urandom), 1'b0);
      g++;
      if (px_valid) sent++;
      if (en1 === 1'b1) wn++;
      checks++;
      if (act(1) !== exp_vec(1) || rb1 !== 2'd1)
        $display("FAIL drop cyc %0d got %h want %h",
                 g, act(1), exp_vec(1));
      else passed++;
    end
    step(1'b1, 2'd3, 1'b0);
    checks++;
    if (wn !== 32 || en1 !== 1'b0)
      $display("FAIL drop_hold got w=%0d e=%b want w=32 e=0", wn, en1);
    else passed++;
    checks++;
    if (dr1 !== 8'd2)
      $display("FAIL drop_count got %0d want 2", dr1);
    else passed++;
    repeat (260 * 32) begin
      step(1'b1, 2'($urandom), 1'b0);
      checks++;
      if (act(1) !== exp_vec(1))
        $display("FAIL saturate got %h want %h", act(1), exp_vec(1));
      else passed++;
    end
    checks++;
    if (dr1 !== 8'd255)
      $display("FAIL saturate_count got %0d want 255", dr1);
    else passed++;
  endtask

  task automatic test_three_bank();
    int sent = 0, g = 0;
    apply_reset();
    while (sent < 64 && g < 600) begin
      step(rv(), 2'($urandom), 1'b0);
      g++;
      if (px_valid) sent++;
      checks++;
      if (act(2) !== exp_vec(2))
        $display("FAIL tri cyc %0d got %h want %h",
                 g, act(2), exp_vec(2));
      else passed++;
    end
    checks++;
    if (pv2 !== 1'b1 || dr2 !== 8'd1 || sent !== 64)
      $display("FAIL tri_pending got p=%b d=%0d want p=1 d=1", pv2, dr2);
    else passed++;
    rd_ack_tgl = ~rd_ack_tgl;
    repeat (4) step(1'b0, 2'd0, 1'b0);
    checks++;
    if (rb2 !== 2'd1 || wb2 === rb2 || pv2 !== 1'b0)
      $display("FAIL tri_ack got w=%0d r=%0d p=%b want r=1 p=0",
               wb2, rb2, pv2);
    else passed++;
  endtask

  task automatic test_three_bank_collide();
    apply_reset();
    repeat (31) step(1'b1, 2'($urandom), 1'b0);
    rd_ack_tgl = ~rd_ack_tgl;
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    checks++;
    if (act(2) !== exp_vec(2))
      $display("FAIL collide got %h want %h", act(2), exp_vec(2));
    else passed++;
    checks++;
    if (fd2 !== 1'b1 || rb2 !== 2'd0 || wb2 !== 2'd2 ||
        pv2 !== 1'b0 || dr2 !== 8'd0)
      $display("FAIL collide_roles got f=%b w=%0d r=%0d p=%b d=%0d want 1 2 0 0 0",
               fd2, wb2, rb2, pv2, dr2);
    else passed++;
  endtask

  task automatic test_vsync();
    int fdn = 0;
    int ea;
    ea = RESYNC ? 0 : 1000;
    apply_reset();
    repeat (1000) begin
      step(1'b1, 2'($urandom), 1'b0);
      if (fd0 === 1'b1) fdn++;
    end
    step(1'b0, 2'd0, 1'b1);
    checks++;
    if (re0 !== RESYNC)
      $display("FAIL vsync_err got %b want %b", re0, RESYNC);
    else passed++;
    step(1'b1, 2'd1, 1'b0);
    if (fd0 === 1'b1) fdn++;
    checks++;
    if (en0 !== 1'b1 || int'(addr0) !== ea)
      $display("FAIL vsync_addr got e=%b a=%0d want e=1 a=%0d",
               en0, addr0, ea);
    else passed++;
    checks++;
    if (fdn !== 0 || wb0 !== 2'd0 || rb0 !== 2'd1 || re0 !== 1'b0)
      $display("FAIL vsync_banks got f=%0d w=%0d r=%0d want 0 0 1",
               fdn, wb0, rb0);
    else passed++;
    checks++;
    if (act(1) !== exp_vec(1) || act(2) !== exp_vec(2))
      $display("FAIL vsync_small got %h %h want %h %h",
               act(1), act(2), exp_vec(1), exp_vec(2));
    else passed++;
  endtask

  task automatic test_random();
    logic vs;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) rd_ack_tgl = ~rd_ack_tgl;
      vs = ($urandom_range(0, 127) == 0);
      step(vs ? 1'b0 : rv(), 2'($urandom), vs);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act(i) !== exp_vec(i))
          $display("FAIL random cyc %0d dut%0d got %h want %h",
                   c, i, act(i), exp_vec(i));
        else passed++;
      end
      checks++;
      if (wb0 === rb0 || wb1 === rb1 || wb2 === rb2)
        $display("FAIL bank_overlap cyc %0d got %0d%0d %0d%0d %0d%0d want distinct",
                 c, wb0, rb0, wb1, rb1, wb2, rb2);
      else passed++;
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_two_bank_skip();
    test_two_bank_drop();
    test_three_bank();
    test_three_bank_collide();
    test_vsync();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
